// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI slave, all CPOL/CPHA modes, MSB first, one-deep tx buffer.
module spi_slave #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  SCLK,
   input  logic                  MOSI,
   input  logic                  SS,
   output logic                  MISO,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_load,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy
);
   localparam int CW = $clog2(DATA_WIDTH + 1);
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_XFER} state_t;
   state_t                r_state;
   logic [2:0]            r_sclk;
   logic [2:0]            r_ss;
   logic [1:0]            r_mosi;
   logic                  r_cpol, r_cpha, r_miso, r_tx_ready, r_rx_valid;
   logic [DATA_WIDTH-1:0] r_buf, r_tx_sh, r_rx_sh, r_rx_data;
   logic [CW-1:0]         r_cnt;
   logic                  w_edge, w_lead, w_trail, w_sample, w_shift, w_ss_fall;
   logic [DATA_WIDTH-1:0] w_rx_next;
   assign w_edge    = r_sclk[1] ^ r_sclk[2];
   assign w_lead    = w_edge & (r_sclk[1] != r_cpol);
   assign w_trail   = w_edge & (r_sclk[1] == r_cpol);
   assign w_sample  = r_cpha ? w_trail : w_lead;
   assign w_shift   = r_cpha ? w_lead : w_trail;
   assign w_ss_fall = r_ss[2] & ~r_ss[1];
   assign w_rx_next = {r_rx_sh[DATA_WIDTH-2:0], r_mosi[1]};
   assign MISO      = r_miso;
   assign tx_ready  = r_tx_ready;
   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign busy      = (r_state != S_IDLE);
   // A shift edge seen with the counter at zero is either the skipped first
   // leading edge (cpha=1) or the previous frame's last trailing edge (cpha=0).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_sclk     <= '0;
         r_ss       <= '0;
         r_mosi     <= '0;
         r_cpol     <= 1'b0;
         r_cpha     <= 1'b0;
         r_miso     <= 1'b0;
         r_tx_ready <= 1'b1;
         r_rx_valid <= 1'b0;
         r_buf      <= '0;
         r_tx_sh    <= '0;
         r_rx_sh    <= '0;
         r_rx_data  <= '0;
         r_cnt      <= '0;
      end else begin
         r_sclk     <= {r_sclk[1:0], SCLK};
         r_ss       <= {r_ss[1:0], SS};
         r_mosi     <= {r_mosi[0], MOSI};
         r_rx_valid <= 1'b0;
         if (tx_load) begin
            r_buf      <= tx_data;
            r_tx_ready <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               r_miso <= 1'b0;
               if (w_ss_fall) begin
                  r_cpol  <= cpol;
                  r_cpha  <= cpha;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (r_ss[1]) begin
                  r_state <= S_IDLE;
                  r_miso  <= 1'b0;
               end else begin
                  r_tx_sh <= r_tx_ready ? '0 : r_buf;
                  r_miso  <= ~r_tx_ready & r_buf[DATA_WIDTH-1];
                  if (!tx_load) r_tx_ready <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_XFER;
               end
            end
            S_XFER: begin
               if (w_sample && r_cnt == CW'(DATA_WIDTH - 1)) begin
                  r_rx_sh    <= w_rx_next;
                  r_rx_data  <= w_rx_next;
                  r_rx_valid <= 1'b1;
                  r_state    <= r_ss[1] ? S_IDLE : S_LOAD;
                  if (r_ss[1]) r_miso <= 1'b0;
               end else if (r_ss[1]) begin
                  r_state <= S_IDLE;
                  r_miso  <= 1'b0;
               end else if (w_sample) begin
                  r_rx_sh <= w_rx_next;
                  r_cnt   <= r_cnt + 1'b1;
               end else if (w_shift && r_cnt != '0) begin
                  r_tx_sh <= {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
                  r_miso  <= r_tx_sh[DATA_WIDTH-2];
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: table-driven SPI mode vectors plus hand-written multi-frame, abort and reset sequences.
module tb_spi_slave;
   localparam int H = 8;
   logic       clk = 0, reset = 1, SCLK = 0, MOSI = 0, SS = 1, cpol = 0, cpha = 0, tx_load = 0;
   logic [7:0] tx_data = 0;
   logic       MISO, tx_ready, rx_valid, busy;
   logic [7:0] rx_data;
   int         pass_n = 0, total_n = 0, rxv_n = 0, n0;
   logic [7:0] mi, m1, m2;

   typedef struct {
      logic       p, h;
      logic [7:0] mo, tx;
      logic       ld;
      logic [7:0] miso;
   } vec_t;
   vec_t v[5];

   spi_slave #(.DATA_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO),
      .cpol(cpol), .cpha(cpha), .tx_data(tx_data), .tx_load(tx_load),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (rx_valid) rxv_n++;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total_n++;
      if (a === e) pass_n++;
      else $display("FAIL %s: got %0h expected %0h", n, a, e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sbit(input logic b, output logic m);
      if (!cpha) begin
         MOSI = b; tick(H); m = MISO; SCLK = ~cpol; tick(H); SCLK = cpol;
      end else begin
         SCLK = ~cpol; MOSI = b; tick(H); m = MISO; SCLK = cpol; tick(H);
      end
   endtask

   task automatic frame(input logic [7:0] mo, input int n, output logic [7:0] r);
      logic m;
      r = '0;
      for (int i = 0; i < n; i++) begin
         sbit(mo[7-i], m);
         r[7-i] = m;
      end
   endtask

   task automatic load(input logic [7:0] d);
      tx_data = d; tx_load = 1; tick(1); tx_load = 0;
   endtask

   task automatic sel(input logic p, input logic h);
      cpol = p; cpha = h; SCLK = p; tick(4); SS = 0; tick(10);
   endtask

   task automatic desel;
      tick(H); SS = 1; tick(10);
   endtask

   initial begin
      v[0] = '{p:0, h:0, mo:8'hCC, tx:8'hAA, ld:1, miso:8'hAA};
      v[1] = '{p:1, h:1, mo:8'h5A, tx:8'h3C, ld:1, miso:8'h3C};
      v[2] = '{p:0, h:1, mo:8'h96, tx:8'h69, ld:1, miso:8'h69};
      v[3] = '{p:1, h:0, mo:8'h0F, tx:8'hF0, ld:1, miso:8'hF0};
      v[4] = '{p:0, h:0, mo:8'h55, tx:8'hEE, ld:0, miso:8'h00};
      tick(3);
      chk("rst_miso", MISO, 0);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_busy", busy, 0);
      reset = 0;
      tick(2);
      for (int i = 0; i < 5; i++) begin
         n0 = rxv_n;
         if (v[i].ld) load(v[i].tx);
         sel(v[i].p, v[i].h);
         chk("vec_busy", busy, 1);
         chk("vec_tx_ready", tx_ready, 1);
         frame(v[i].mo, 8, mi);
         chk("vec_miso", mi, v[i].miso);
         chk("vec_rx_data", rx_data, v[i].mo);
         desel;
         chk("vec_rx_pulses", rxv_n - n0, 1);
         chk("vec_idle", busy, 0);
      end
      n0 = rxv_n;
      sel(0, 0);
      frame(8'hF0, 4, mi);
      desel;
      chk("abort_no_valid", rxv_n - n0, 0);
      chk("abort_rx_kept", rx_data, 8'h55);
      chk("abort_idle", busy, 0);
      sel(0, 0);
      frame(8'h81, 8, mi);
      desel;
      chk("after_abort_rx", rx_data, 8'h81);
      chk("after_abort_pulses", rxv_n - n0, 1);
      n0 = rxv_n;
      load(8'h11);
      sel(0, 0);
      frame(8'h12, 4, m1);
      load(8'h77);
      chk("b2b_reload_ready", tx_ready, 0);
      frame(8'h20, 4, m2);
      chk("b2b_miso1", {m1[7:4], m2[7:4]}, 8'h11);
      chk("b2b_rx1", rx_data, 8'h12);
      chk("b2b_pulses1", rxv_n - n0, 1);
      frame(8'h34, 8, mi);
      chk("b2b_miso2", mi, 8'h77);
      chk("b2b_rx2", rx_data, 8'h34);
      desel;
      chk("b2b_pulses2", rxv_n - n0, 2);
      n0 = rxv_n;
      load(8'hE7);
      sel(0, 0);
      frame(8'hFF, 5, mi);
      reset = 1;
      tick(1);
      chk("mid_rst_miso", MISO, 0);
      chk("mid_rst_tx_ready", tx_ready, 1);
      chk("mid_rst_rx_data", rx_data, 0);
      chk("mid_rst_busy", busy, 0);
      reset = 0;
      SS = 1;
      tick(10);
      chk("mid_rst_no_valid", rxv_n - n0, 0);
      sel(0, 0);
      frame(8'hA5, 8, mi);
      desel;
      chk("post_rst_rx", rx_data, 8'hA5);
      chk("post_rst_miso", mi, 8'h00);
      chk("post_rst_pulses", rxv_n - n0, 1);
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule
